// File: rtl/parity_pkg.sv
// Shared types and default widths for the streaming parity unit.
package parity_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_mode_t;

  // Output-stage occupancy; the encoding doubles as out_valid.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_t;

endpackage

// File: rtl/parity_tree.sv
// Combinational parity of one data word, even or odd selectable.
module parity_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_mode,
  output logic              par
);

  assign par = (par_mode_t'(odd_mode) == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with one registered valid/ready stage
// and error status. Define PARITY_ERR_CNT_EN to build the saturating error counter.
module parity_stream_unit
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              odd_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr
);

  out_state_t        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_par_q, out_par_d;
  logic              out_err_q, out_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic              gen;
  logic              err;
  logic              accept;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data     (in_data),
    .odd_mode (odd_mode),
    .par      (gen)
  );

  assign err      = in_par ^ gen;
  assign in_ready = (state_q == ST_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_par_d    = out_par_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;

    if (accept) begin
      state_d    = ST_FULL;
      out_data_d = in_data;
      out_par_d  = gen;
      out_err_d  = err;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end

    // Clear wins over a simultaneous error; the beat itself still carries out_err.
    if (clr) begin
      err_sticky_d = 1'b0;
    end else if (accept && err) begin
      err_sticky_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well, so consumers see defined zeros.
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_par_q    <= 1'b0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_par_q    <= out_par_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = out_data_q;
  assign out_par    = out_par_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (accept && err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_stream_unit.sv
// Self-checking bench for parity_stream_unit against a queue-based behavioural model.
module tb_parity_stream_unit;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_par, odd_mode, out_ready, clr;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_par, out_err, err_sticky;
  logic [DW-1:0] out_data;
  logic [CW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          p;
    logic          e;
  } beat_t;

  beat_t pend[$];
  int    errs   = 0;
  logic  sticky = 1'b0;

  parity_stream_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .odd_mode   (odd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .clr        (clr)
  );

  always #5 clk = ~clk;

  // Parity bit that makes data+bit even (odd=0) or odd (odd=1) in ones.
  function automatic logic ref_par(input logic [DW-1:0] d, input logic odd);
    int ones;
    ones = $countones(d);
    return logic'(ones % 2) ^ odd;
  endfunction

  function automatic logic [CW-1:0] ref_cnt();
`ifdef PARITY_ERR_CNT_EN
    int cap;
    cap = (1 << CW) - 1;
    return CW'((errs > cap) ? cap : errs);
`else
    return '0;
`endif
  endfunction

  // One clock of stimulus; compares in_ready before the edge and all outputs after it.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic p,
                      input logic m, input logic ordy, input logic c);
    logic  exp_ready;
    beat_t b;
    in_valid = v; in_data = d; in_par = p; odd_mode = m; out_ready = ordy; clr = c;
    #1;
    exp_ready = (pend.size() == 0) || ordy;
    n_checks++;
    if (in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
    end
    @(posedge clk);
    if (ordy && pend.size() != 0) void'(pend.pop_front());
    if (v && exp_ready) begin
      b.d = d;
      b.p = ref_par(d, m);
      b.e = (p != b.p);
      pend.push_back(b);
      if (b.e) begin
        errs++;
        sticky = 1'b1;
      end
    end
    if (c) begin
      errs   = 0;
      sticky = 1'b0;
    end
    #1;
    n_checks++;
    if (out_valid !== (pend.size() != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, pend.size() != 0, $time);
    end
    if (pend.size() != 0) begin
      n_checks++;
      if ({out_data, out_par, out_err} !== {pend[0].d, pend[0].p, pend[0].e}) begin
        n_fail++;
        $display("FAIL out_beat: got d=%h p=%b e=%b expected d=%h p=%b e=%b at %0t",
                 out_data, out_par, out_err, pend[0].d, pend[0].p, pend[0].e, $time);
      end
    end
    n_checks++;
    if ({err_sticky, err_cnt} !== {sticky, ref_cnt()}) begin
      n_fail++;
      $display("FAIL status: got sticky=%b cnt=%0d expected sticky=%b cnt=%0d at %0t",
               err_sticky, err_cnt, sticky, ref_cnt(), $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    errs   = 0;
    sticky = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h3C; in_par = 1'b1;
    odd_mode = 1'b0; out_ready = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_data, out_par, out_err, err_sticky, err_cnt, in_ready} !==
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_values: got v=%b d=%h p=%b e=%b s=%b c=%0d rdy=%b expected zeros and rdy=1",
                 out_valid, out_data, out_par, out_err, err_sticky, err_cnt, in_ready);
      end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_even();
    tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({out_par, out_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL even_a5: got p=%b e=%b expected p=0 e=0", out_par, out_err);
    end
    tick(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({out_par, out_err, err_sticky} !== 3'b111) begin
      n_fail++;
      $display("FAIL even_01: got p=%b e=%b s=%b expected p=1 e=1 s=1", out_par, out_err, err_sticky);
    end
  endtask

  task automatic test_odd();
    tick(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({out_par, out_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL odd_00: got p=%b e=%b expected p=1 e=0", out_par, out_err);
    end
    tick(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({out_par, out_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL odd_07: got p=%b e=%b expected p=0 e=1", out_par, out_err);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [DW+1:0] snap;
    tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    snap = {out_data, out_par, out_err};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'(i + 8'h10), 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, in_ready, out_data, out_par, out_err} !== {1'b1, 1'b0, snap}) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b rdy=%b beat=%h expected v=1 rdy=0 beat=%h",
                 out_valid, in_ready, {out_data, out_par, out_err}, snap);
      end
    end
    tick(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL drain_reload: got d=%h expected d=c3", out_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'(8'hE0 + i), 1'(i), 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (out_data !== 8'(8'hE0 + i)) begin
        n_fail++;
        $display("FAIL burst_beat%0d: got d=%h expected d=%h", i, out_data, 8'(8'hE0 + i));
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation_clear();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      tick(1'b1, d, ~ref_par(d, 1'b0), 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (err_cnt !== ref_cnt()) begin
      n_fail++;
      $display("FAIL saturate: got cnt=%0d expected cnt=%0d", err_cnt, ref_cnt());
    end
    tick(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({out_err, err_sticky, err_cnt} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL clr_priority: got e=%b s=%b c=%0d expected e=1 s=0 c=0", out_err, err_sticky, err_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(3, 0) != 0), ($urandom_range(24, 0) == 0));
    end
  endtask

  task automatic test_midstream_reset();
    tick(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, err_cnt, err_sticky, in_ready} !== {1'b0, 4'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b c=%0d s=%b rdy=%b expected v=0 c=0 s=0 rdy=1",
               out_valid, err_cnt, err_sticky, in_ready);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_backpressure();
    test_saturation_clear();
    test_random();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_stream_unit.md
# parity_stream_unit

Streaming parity generator/checker, successor to the fixed 4-bit combinational parity generator. It is parametrised in data width, selects even or odd parity per beat, and checks a received parity bit. It carries each word through one registered valid/ready stage and accumulates error status (sticky flag plus saturating counter). It sits between a word source and a consumer, appending a generated parity bit and flagging corrupted words.

## Interface
- `DATA_W`, default 8: data word width, ≥ 1.
- `CNT_W`, default 16: error counter width, ≥ 1.

- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `in_valid`: in, 1. Input beat present.
- `in_ready`: out, 1. Unit accepts a beat this cycle.
- `in_data`: in, DATA_W. Data word.
- `in_par`: in, 1. Received parity bit to check.
- `odd_mode`: in, 1. 0 selects even parity, 1 selects odd parity; sampled with the beat.
- `out_valid`: out, 1. Output register holds a beat.
- `out_ready`: in, 1. Consumer accepts the beat.
- `out_data`: out, DATA_W. Registered copy of `in_data`.
- `out_par`: out, 1. Generated parity bit.
- `out_err`: out, 1. `in_par` differed from the generated parity for this beat.
- `err_sticky`: out, 1. Set by any accepted erroneous beat.
- `err_cnt`: out, CNT_W. Saturating count of accepted erroneous beats.
- `clr`: in, 1. Synchronous clear of `err_sticky` and `err_cnt`.

## Operation
- Even parity: `gen = ^in_data`, so the data plus the parity bit has an even count of ones. Odd parity: `gen = ~^in_data`.
- `err = (in_par != gen)`.
- Accept condition: `in_valid && in_ready`.
- Output stage is a 2-state FSM, EMPTY/FULL, encoded as `out_valid`:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `out_ready` with no accept.
  - FULL stays FULL on accept with `out_ready`: the register reloads and throughput is 1 beat/cycle.
- `in_ready = !out_valid || out_ready`, combinational from `out_ready`. It never depends on `in_valid`.
- On accept, load `out_data = in_data`, `out_par = gen`, `out_err = err`.
- While FULL and `out_ready=0`, all `out_*` hold stable.
- Error status updates on accept with `err=1`, independent of output drain:
  - `err_sticky` ← 1.
  - `err_cnt` ← `err_cnt + 1`, saturating at all-ones. No wrap.
- `clr` has priority: in a cycle where `clr=1`, `err_sticky` and `err_cnt` go to 0 even if an erroneous beat is accepted in that cycle. That beat still reaches `out_err=1`.
- Reset values: `out_valid=0`, `out_data=0`, `out_par=0`, `out_err=0`, `err_sticky=0`, `err_cnt=0`. `in_ready=1` during and after reset.
- Reset mid-stream: any held beat is discarded, and a beat offered during the reset cycle is not accepted.

## Timing
- Latency: 1 cycle, from accept edge to `out_valid`/`out_data`/`out_par`/`out_err`.
- Status latency: `err_sticky`/`err_cnt` reflect an error on the cycle after its accept edge. This is the same cycle as `out_err`.
- `rst` and `clr` take effect on the next rising edge. No combinational path from `in_data` to any output.
- Only `in_ready` is combinational from an input (`out_ready`).

## Configuration
- `PARITY_ERR_CNT_EN`:
  - Defined: the `err_cnt` register and its saturating increment/clear logic are compiled in.
  - Undefined: `err_cnt` is tied to 0, `CNT_W` is unused, and no counter flops exist.
  - Unaffected either way: `err_sticky`, `out_err` and the data path.

## Structure
- Package `parity_pkg`:
  - `typedef enum logic {PAR_EVEN=1'b0, PAR_ODD=1'b1} par_mode_t`.
  - Output-stage state constants `ST_EMPTY`/`ST_FULL`.
  - Default-width localparams.
- Sub-module `parity_tree`: purely combinational, parameter `DATA_W`. Inputs `data`, `odd_mode`; output `par`. Reused for any future multi-lane version.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `in_valid=1` → all outputs 0, `in_ready=1`, and no beat appears afterward.
- Even mode: `8'hA5` with `in_par=0` → next cycle `out_par=0`, `out_err=0`. Then `8'h01` with `in_par=0` → `out_par=1`, `out_err=1`, `err_sticky=1`, `err_cnt=1`.
- Odd mode: `8'h00` with `in_par=1` → `out_par=1`, `out_err=0`. `8'h07` with `in_par=1` → `out_par=0`, `out_err=1`.
- Backpressure: with `out_valid=1`, hold `out_ready=0` for 5 cycles → `in_ready=0` and `out_*` stable. Raise `out_ready` → the held beat drains and the next beat loads in the same cycle. A 4-beat burst completes in 4 cycles.
- Saturation and clear: `CNT_W=4`, 20 erroneous beats → `err_cnt=15`, held. `clr=1` in the same cycle as an error → `err_cnt=0`, `err_sticky=0`, and that beat's `out_err=1`.
- Mid-stream reset: `rst=1` while FULL and `out_ready=0` → next cycle `out_valid=0` and `err_cnt=0`; the held beat is never presented.
